// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: opcode constants, the
// u_control operand-select encoding and the per-stage control bundle.
// When CTRL_PIPE_ILLEGAL_TRAP_EN is defined, the bundle gains an illegal bit.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] UCTRL_NONE  = 2'd0;
    localparam logic [1:0] UCTRL_LUI   = 2'd1;
    localparam logic [1:0] UCTRL_AUIPC = 2'd2;
    localparam logic [1:0] UCTRL_JALR  = 2'd3;

    typedef struct packed {
        logic [1:0] u_ctrl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder producing one control bundle.
// With CTRL_PIPE_ILLEGAL_TRAP_EN defined, unknown opcodes raise the illegal
// bit; otherwise they simply decode to an all-zero bundle.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t bundle_o
);

    // Map each recognised opcode onto its control bits; everything else is zero
    always_comb begin
        bundle_o = '0;
        case (opcode_i)
            OPC_LUI: begin
                bundle_o.u_ctrl    = UCTRL_LUI;
                bundle_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                bundle_o.u_ctrl    = UCTRL_AUIPC;
                bundle_o.reg_write = 1'b1;
            end
            OPC_JAL: begin
                bundle_o.u_ctrl    = UCTRL_NONE;
                bundle_o.jump      = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            OPC_JALR: begin
                bundle_o.u_ctrl    = UCTRL_JALR;
                bundle_o.jump      = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                bundle_o.branch = 1'b1;
            end
            OPC_LOAD: begin
                bundle_o.mem_read  = 1'b1;
                bundle_o.reg_write = 1'b1;
            end
            OPC_STORE: begin
                bundle_o.mem_write = 1'b1;
            end
            OPC_OP_IMM, OPC_OP: begin
                bundle_o.reg_write = 1'b1;
            end
            default: begin
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
                bundle_o.illegal = 1'b1;
`else
                bundle_o = '0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_gen.sv
// Control pipeline: decodes opcode_in and carries the control bundle through
// STAGES registered stages with stall/flush, a retired-bundle counter and,
// when CTRL_PIPE_ILLEGAL_TRAP_EN is defined, a sticky illegal-opcode flag.
module ctrl_pipe_gen
    import ctrl_pkg::*;
#(
    parameter int STAGES  = 3,
    parameter int UCTRL_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode_in,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic               valid_o,
    output logic [UCTRL_W-1:0] u_control_o,
    output logic               reg_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               illegal_o,
    output logic               illegal_seen_o,
    output logic [CNT_W-1:0]   retired_cnt_o
);

    ctrl_bundle_t                dec_bundle;
    ctrl_bundle_t [STAGES-1:0]   stage_q;
    ctrl_bundle_t [STAGES-1:0]   stage_d;
    logic         [STAGES-1:0]   valid_q;
    logic         [STAGES-1:0]   valid_d;
    logic         [CNT_W-1:0]    cnt_q;
    logic         [CNT_W-1:0]    cnt_d;
    ctrl_bundle_t                out_bundle;
    logic                        retire;

    ctrl_decode u_decode (
        .opcode_i (opcode_in),
        .bundle_o (dec_bundle)
    );

    assign out_bundle = stage_q[STAGES-1];
    assign retire     = valid_q[STAGES-1] & ~stall & ~flush;

    // Advance, hold or clear the stages; flush takes priority over stall
    always_comb begin
        valid_d = valid_q;
        stage_d = stage_q;
        if (flush) begin
            valid_d = '0;
            stage_d = '0;
        end else if (!stall) begin
            valid_d[0] = in_valid;
            stage_d[0] = in_valid ? dec_bundle : ctrl_bundle_t'('0);
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Count bundles that actually leave the final stage, wrapping naturally
    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive the final-stage bundle, forcing zeros while it is not valid
    always_comb begin
        u_control_o      = '0;
        u_control_o[1:0] = valid_o ? out_bundle.u_ctrl : 2'b00;
    end

    assign valid_o       = valid_q[STAGES-1];
    assign reg_write_o   = valid_o & out_bundle.reg_write;
    assign mem_read_o    = valid_o & out_bundle.mem_read;
    assign mem_write_o   = valid_o & out_bundle.mem_write;
    assign branch_o      = valid_o & out_bundle.branch;
    assign jump_o        = valid_o & out_bundle.jump;
    assign retired_cnt_o = cnt_q;

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
    logic seen_q;
    logic seen_d;

    // Latch the sticky flag when an illegal bundle retires
    always_comb begin
        seen_d = seen_q | (retire & out_bundle.illegal);
    end

    // Sticky flag register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

    assign illegal_o      = valid_o & out_bundle.illegal;
    assign illegal_seen_o = seen_q;
`else
    assign illegal_o      = 1'b0;
    assign illegal_seen_o = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// Scoreboard testbench for ctrl_pipe_gen (STAGES=3, CNT_W=4).
// Expected bundles are queued at issue time; a negedge monitor compares them
// when the DUT presents valid_o. Honours CTRL_PIPE_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module tb_ctrl_pipe_gen;

    localparam int STAGES  = 3;
    localparam int UCTRL_W = 2;
    localparam int CNT_W   = 4;

    // Expected bundle encoding: {u[1:0], reg_write, mem_read, mem_write, branch, jump, illegal}
    localparam logic [7:0] E_LUI    = 8'h60;
    localparam logic [7:0] E_AUIPC  = 8'hA0;
    localparam logic [7:0] E_JAL    = 8'h22;
    localparam logic [7:0] E_JALR   = 8'hE2;
    localparam logic [7:0] E_STORE  = 8'h08;
    localparam logic [7:0] E_ALU    = 8'h20;
    localparam logic [7:0] E_LOAD   = 8'h30;
    localparam logic [7:0] E_BRANCH = 8'h04;
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
    localparam logic [7:0] E_ILL    = 8'h01;
    localparam logic       EXP_SEEN = 1'b1;
`else
    localparam logic [7:0] E_ILL    = 8'h00;
    localparam logic       EXP_SEEN = 1'b0;
`endif

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [6:0]         opcode_in;
    logic               in_valid;
    logic               stall;
    logic               flush;
    logic               valid_o;
    logic [UCTRL_W-1:0] u_control_o;
    logic               reg_write_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic               branch_o;
    logic               jump_o;
    logic               illegal_o;
    logic               illegal_seen_o;
    logic [CNT_W-1:0]   retired_cnt_o;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] act;
    bit         mon_en = 1'b0;

    ctrl_pipe_gen #(
        .STAGES  (STAGES),
        .UCTRL_W (UCTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .opcode_in      (opcode_in),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .valid_o        (valid_o),
        .u_control_o    (u_control_o),
        .reg_write_o    (reg_write_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .branch_o       (branch_o),
        .jump_o         (jump_o),
        .illegal_o      (illegal_o),
        .illegal_seen_o (illegal_seen_o),
        .retired_cnt_o  (retired_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, optionally queue the expected bundle, then step past the edge
    task automatic applyStimulus(input logic [6:0] op, input logic v, input logic st,
                                 input logic fl, input logic push, input logic [7:0] exp_b);
        opcode_in = op;
        in_valid  = v;
        stall     = st;
        flush     = fl;
        if (push) exp_q.push_back(exp_b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: compare the presented bundle against the queue head at each falling edge
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            act = {u_control_o[1:0], reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, illegal_o};
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_bundle", {24'd0, act}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("bundle", {24'd0, act}, {24'd0, exp_q[0]});
                    if (!stall || flush) void'(exp_q.pop_front());
                end
            end else begin
                checkOutput("bubble_zero", {24'd0, act}, 32'd0);
            end
        end
    end

    initial begin
        opcode_in = '0;
        in_valid  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("reset_cnt", {28'd0, retired_cnt_o}, 32'd0);
        checkOutput("reset_seen", {31'd0, illegal_seen_o}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Single LUI: appears exactly three cycles after issue, then a bubble
        applyStimulus(OP_LUI, 1'b1, 1'b0, 1'b0, 1'b1, E_LUI);
        checkOutput("lui_lat1", {31'd0, valid_o}, 32'd0);
        idle(1);
        checkOutput("lui_lat2", {31'd0, valid_o}, 32'd0);
        idle(1);
        checkOutput("lui_lat3", {31'd0, valid_o}, 32'd1);
        checkOutput("lui_u", {30'd0, u_control_o}, 32'd1);
        idle(1);
        checkOutput("lui_bubble", {31'd0, valid_o}, 32'd0);
        checkOutput("lui_cnt", {28'd0, retired_cnt_o}, 32'd1);

        // Back-to-back AUIPC, JAL, JALR, STORE
        applyStimulus(OP_AUIPC, 1'b1, 1'b0, 1'b0, 1'b1, E_AUIPC);
        applyStimulus(OP_JAL,   1'b1, 1'b0, 1'b0, 1'b1, E_JAL);
        applyStimulus(OP_JALR,  1'b1, 1'b0, 1'b0, 1'b1, E_JALR);
        applyStimulus(OP_STORE, 1'b1, 1'b0, 1'b0, 1'b1, E_STORE);
        idle(4);
        checkOutput("b2b_cnt", {28'd0, retired_cnt_o}, 32'd5);

        // Two-cycle stall with three bundles in flight; the opcode offered while stalled is ignored
        applyStimulus(OP_OPIMM,  1'b1, 1'b0, 1'b0, 1'b1, E_ALU);
        applyStimulus(OP_LOAD,   1'b1, 1'b0, 1'b0, 1'b1, E_LOAD);
        applyStimulus(OP_BRANCH, 1'b1, 1'b0, 1'b0, 1'b1, E_BRANCH);
        checkOutput("stall_pre_valid", {31'd0, valid_o}, 32'd1);
        applyStimulus(OP_LUI, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("stall1_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("stall1_cnt", {28'd0, retired_cnt_o}, 32'd5);
        applyStimulus(OP_LUI, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("stall2_cnt", {28'd0, retired_cnt_o}, 32'd5);
        idle(1);
        checkOutput("resume_cnt", {28'd0, retired_cnt_o}, 32'd6);
        idle(3);
        checkOutput("stall_end_cnt", {28'd0, retired_cnt_o}, 32'd8);

        // Flush together with stall: only the bundle already on the output is seen
        applyStimulus(OP_OP,  1'b1, 1'b0, 1'b0, 1'b1, E_ALU);
        applyStimulus(OP_JAL, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(OP_LUI, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(OP_AUIPC, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("flush_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("flush_cnt", {28'd0, retired_cnt_o}, 32'd8);
        idle(5);
        checkOutput("flush_end_cnt", {28'd0, retired_cnt_o}, 32'd8);

        // Unrecognised opcode
        applyStimulus(OP_ILL, 1'b1, 1'b0, 1'b0, 1'b1, E_ILL);
        idle(2);
        checkOutput("ill_valid", {31'd0, valid_o}, 32'd1);
        checkOutput("ill_seen_early", {31'd0, illegal_seen_o}, 32'd0);
        idle(1);
        checkOutput("ill_seen", {31'd0, illegal_seen_o}, {31'd0, EXP_SEEN});
        checkOutput("ill_cnt", {28'd0, retired_cnt_o}, 32'd9);
        idle(2);
        checkOutput("ill_seen_hold", {31'd0, illegal_seen_o}, {31'd0, EXP_SEEN});

        // Asynchronous reset mid-stream discards everything in flight
        applyStimulus(OP_LOAD,   1'b1, 1'b0, 1'b0, 1'b1, E_LOAD);
        applyStimulus(OP_STORE,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(OP_BRANCH, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #6;
        rst_n = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("arst_cnt", {28'd0, retired_cnt_o}, 32'd0);
        checkOutput("arst_seen", {31'd0, illegal_seen_o}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_bubble", {31'd0, valid_o}, 32'd0);
        applyStimulus(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b1, E_JALR);
        checkOutput("post_rst_b1", {31'd0, valid_o}, 32'd0);
        idle(1);
        checkOutput("post_rst_b2", {31'd0, valid_o}, 32'd0);
        idle(1);
        checkOutput("post_rst_out", {31'd0, valid_o}, 32'd1);
        idle(2);

        // Fresh reset, then 17 bundles to wrap the 4-bit counter
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) applyStimulus(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b1, E_LOAD);
        checkOutput("wrap_cnt14", {28'd0, retired_cnt_o}, 32'd14);
        idle(1);
        checkOutput("wrap_cnt15", {28'd0, retired_cnt_o}, 32'd15);
        idle(1);
        checkOutput("wrap_cnt0", {28'd0, retired_cnt_o}, 32'd0);
        idle(1);
        checkOutput("wrap_cnt1", {28'd0, retired_cnt_o}, 32'd1);
        idle(3);
        checkOutput("wrap_final", {28'd0, retired_cnt_o}, 32'd1);

        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
